// File: rtl/rx_dma_packetizer.sv
`default_nettype none
// ============================================================================
// Module      : rx_dma_packetizer
// Description : Receive-side sample packetizer. Accepts 16-bit I/Q sample
//               pairs from the ADC capture logic, buffers them in a sample
//               FIFO and serialises each pair into four bytes on an 8-bit
//               AXI-stream master toward the DMA (S2MM). Frames of
//               FRAME_SAMPLES samples are closed with m_axis_last; a partial
//               frame is zero-padded when capture is disabled. Samples that
//               arrive while the FIFO is full are dropped and counted.
//
// Ports       : clk, rst          - clock, synchronous active-high reset
//               enable            - capture enable
//               s_valid/s_i/s_q   - sample strobe and signed I/Q (no ready)
//               m_axis_*          - 8-bit AXI-stream master (valid/ready/
//                                   data/last)
//               overflow          - sticky "sample dropped" flag
//               drop_count        - saturating dropped-sample counter
//               clear_status      - clears overflow and drop_count
//
// Revision    : 1.0 - initial release
// ============================================================================
module rx_dma_packetizer #(
    parameter int FIFO_DEPTH    = 64,
    parameter int FRAME_SAMPLES = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        s_valid,
    input  logic [15:0] s_i,
    input  logic [15:0] s_q,
    output logic        m_axis_valid,
    input  logic        m_axis_ready,
    output logic [7:0]  m_axis_data,
    output logic        m_axis_last,
    output logic        overflow,
    output logic [15:0] drop_count,
    input  logic        clear_status
);

    localparam int c_AW = $clog2(FIFO_DEPTH);
    localparam int c_FW = $clog2(FRAME_SAMPLES);
    localparam logic [c_AW:0]   c_FIFO_FULL  = (c_AW+1)'(FIFO_DEPTH);
    localparam logic [c_FW-1:0] c_FRAME_LAST = c_FW'(FRAME_SAMPLES - 1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_PAD  = 2'd2;

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    logic [1:0]      r_state;
    logic [1:0]      w_state_next;
    logic            w_run_accept;
    logic            w_in_pad;

    logic [32:0]     r_mem [0:FIFO_DEPTH-1];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_AW:0]   r_count;
    logic            w_full;
    logic            w_empty;
    logic            w_sample_write;
    logic            w_pad_write;
    logic            w_push;
    logic            w_pop;
    logic            w_drop;
    logic [32:0]     w_wr_entry;
    logic [32:0]     w_rd_entry;

    logic [c_FW-1:0] r_frame_cnt;
    logic            w_frame_last;

    logic            r_valid;
    logic [7:0]      r_data;
    logic            r_last;
    logic [1:0]      r_byte_idx;
    logic [24:0]     r_hold;        // {frame_last, q[15:0], i[15:8]}
    logic            w_handshake;
    logic [7:0]      w_next_byte;

    logic            r_overflow;
    logic [15:0]     r_drop_count;
    logic [15:0]     w_drop_inc;

    // ------------------------------------------------------------------
    // Capture FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: if (enable) w_state_next = c_ST_RUN;
            c_ST_RUN: begin
                if (!enable) begin
                    w_state_next = (r_frame_cnt == '0) ? c_ST_IDLE : c_ST_PAD;
                end
            end
            c_ST_PAD: if (w_pad_write && w_frame_last) w_state_next = c_ST_IDLE;
            default:  w_state_next = c_ST_IDLE;
        endcase
    end

    // s_valid only counts in RUN while enable is still high; the cycle that
    // drops enable is the transition cycle and carries no sample.
    always_comb begin
        w_run_accept = (r_state == c_ST_RUN) && enable;
        w_in_pad     = (r_state == c_ST_PAD);
    end

    // ------------------------------------------------------------------
    // Sample FIFO
    // ------------------------------------------------------------------
    assign w_full         = (r_count == c_FIFO_FULL);
    assign w_empty        = (r_count == '0);
    assign w_frame_last   = (r_frame_cnt == c_FRAME_LAST);
    assign w_sample_write = w_run_accept && s_valid && !w_full;
    assign w_pad_write    = w_in_pad && !w_full;
    assign w_drop         = w_run_accept && s_valid && w_full;
    assign w_push         = w_sample_write || w_pad_write;
    assign w_wr_entry     = {w_frame_last, (w_pad_write ? 32'd0 : {s_q, s_i})};
    assign w_rd_entry     = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_wr_entry;
        end
    end

    // Fullness is judged on the registered count only, so a pop in the
    // same cycle never makes room for a write.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (c_AW+1)'(1);
                2'b01:   r_count <= r_count - (c_AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Frame position of the next written sample; drops do not advance it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_cnt <= '0;
        end else if (w_push) begin
            r_frame_cnt <= w_frame_last ? '0 : r_frame_cnt + c_FW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Byte serializer
    // ------------------------------------------------------------------
    assign w_handshake = r_valid && m_axis_ready;
    // Reload on the final-byte handshake keeps back-to-back samples bubble-free.
    assign w_pop = (!r_valid || (w_handshake && (r_byte_idx == 2'd3))) && !w_empty;

    always_comb begin
        w_next_byte = r_hold[23:16];
        case (r_byte_idx)
            2'd0:    w_next_byte = r_hold[7:0];
            2'd1:    w_next_byte = r_hold[15:8];
            default: w_next_byte = r_hold[23:16];
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid    <= 1'b0;
            r_data     <= 8'd0;
            r_last     <= 1'b0;
            r_byte_idx <= 2'd0;
            r_hold     <= '0;
        end else if (w_pop) begin
            r_valid    <= 1'b1;
            r_data     <= w_rd_entry[7:0];
            r_last     <= 1'b0;
            r_byte_idx <= 2'd0;
            r_hold     <= w_rd_entry[32:8];
        end else if (w_handshake) begin
            if (r_byte_idx == 2'd3) begin
                r_valid    <= 1'b0;
                r_last     <= 1'b0;
                r_byte_idx <= 2'd0;
            end else begin
                r_data     <= w_next_byte;
                r_last     <= (r_byte_idx == 2'd2) && r_hold[24];
                r_byte_idx <= r_byte_idx + 2'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Status: a drop in the same cycle as clear_status restarts at one.
    // ------------------------------------------------------------------
    assign w_drop_inc = (r_drop_count == 16'hFFFF) ? r_drop_count : r_drop_count + 16'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow   <= 1'b0;
            r_drop_count <= 16'd0;
        end else if (w_drop) begin
            r_overflow   <= 1'b1;
            r_drop_count <= clear_status ? 16'd1 : w_drop_inc;
        end else if (clear_status) begin
            r_overflow   <= 1'b0;
            r_drop_count <= 16'd0;
        end
    end

    assign m_axis_valid = r_valid;
    assign m_axis_data  = r_data;
    assign m_axis_last  = r_last;
    assign overflow     = r_overflow;
    assign drop_count   = r_drop_count;

endmodule
`default_nettype wire

// File: tb/tb_rx_dma_packetizer.sv
`default_nettype none
// ============================================================================
// Module      : tb_rx_dma_packetizer
// Description : Self-checking bench for rx_dma_packetizer (FIFO_DEPTH=4,
//               FRAME_SAMPLES=4). Table-driven stream vectors plus directed
//               sequences for overflow, padding, status and mid-frame reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rx_dma_packetizer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        s_valid = 1'b0;
    logic [15:0] s_i = 16'd0;
    logic [15:0] s_q = 16'd0;
    logic        m_axis_valid;
    logic        m_axis_ready = 1'b0;
    logic [7:0]  m_axis_data;
    logic        m_axis_last;
    logic        overflow;
    logic [15:0] drop_count;
    logic        clear_status = 1'b0;

    int checks = 0;
    int failures = 0;

    // 0: ready=1, 1: toggle each cycle, 2: ready=0, 3: driven by the test
    int rdy_mode = 2;
    logic mon_en = 1'b0;
    logic prev_stall = 1'b0;
    logic [7:0] prev_data = 8'd0;
    logic prev_last = 1'b0;
    logic [8:0] mon_q[$];
    logic [8:0] exp_q[$];

    typedef struct {
        logic [15:0] i;
        logic [15:0] q;
        logic [7:0]  b0, b1, b2, b3;
        logic        last;
    } vec_t;
    vec_t vecs[4];

    rx_dma_packetizer #(.FIFO_DEPTH(4), .FRAME_SAMPLES(4)) dut (
        .clk(clk), .rst(rst), .enable(enable), .s_valid(s_valid),
        .s_i(s_i), .s_q(s_q), .m_axis_valid(m_axis_valid),
        .m_axis_ready(m_axis_ready), .m_axis_data(m_axis_data),
        .m_axis_last(m_axis_last), .overflow(overflow),
        .drop_count(drop_count), .clear_status(clear_status)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0: m_axis_ready = 1'b1;
            1: m_axis_ready = ~m_axis_ready;
            2: m_axis_ready = 1'b0;
            default: ;
        endcase
    end

    // Output monitor: captures handshaken bytes and checks that a stalled
    // beat is held unchanged until it is accepted.
    always @(negedge clk) begin
        if (!mon_en) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                checks++;
                if (!m_axis_valid || m_axis_data !== prev_data || m_axis_last !== prev_last) begin
                    failures++;
                    $display("FAIL stall_hold: got valid=%0b data=%0h last=%0b expected valid=1 data=%0h last=%0b",
                             m_axis_valid, m_axis_data, m_axis_last, prev_data, prev_last);
                end
            end
            if (m_axis_valid && m_axis_ready) mon_q.push_back({m_axis_last, m_axis_data});
            prev_stall = m_axis_valid && !m_axis_ready;
            prev_data  = m_axis_data;
            prev_last  = m_axis_last;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        rst = 1'b1;
        enable = 1'b0;
        s_valid = 1'b0;
        clear_status = 1'b0;
        step();
        step();
        rst = 1'b0;
        mon_q.delete();
        exp_q.delete();
        mon_en = 1'b1;
    endtask

    task automatic send_sample(input logic [15:0] i, input logic [15:0] q, input int gap);
        s_valid = 1'b1;
        s_i = i;
        s_q = q;
        step();
        s_valid = 1'b0;
        repeat (gap) step();
    endtask

    task automatic exp_add(input logic [15:0] i, input logic [15:0] q, input logic last);
        exp_q.push_back({1'b0, i[7:0]});
        exp_q.push_back({1'b0, i[15:8]});
        exp_q.push_back({1'b0, q[7:0]});
        exp_q.push_back({last, q[15:8]});
    endtask

    task automatic exp_add_vecs();
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back({1'b0, vecs[k].b0});
            exp_q.push_back({1'b0, vecs[k].b1});
            exp_q.push_back({1'b0, vecs[k].b2});
            exp_q.push_back({vecs[k].last, vecs[k].b3});
        end
    endtask

    task automatic wait_bytes(input string name, input int n, input int budget);
        int c = 0;
        while (mon_q.size() < n && c < budget) begin
            step();
            c++;
        end
        if (mon_q.size() < n) begin
            checks++;
            failures++;
            $display("FAIL %s timeout: got %0d bytes expected %0d", name, mon_q.size(), n);
        end
        repeat (8) step();
    endtask

    task automatic cmp_stream(input string name);
        chk({name, " count"}, 32'(mon_q.size()), 32'(exp_q.size()));
        for (int k = 0; k < exp_q.size() && k < mon_q.size(); k++) begin
            chk($sformatf("%s byte%0d {last,data}", name, k), 32'(mon_q[k]), 32'(exp_q[k]));
        end
        mon_q.delete();
        exp_q.delete();
    endtask

    initial begin
        vecs[0] = '{i: 16'h1234, q: 16'hABCD, b0: 8'h34, b1: 8'h12, b2: 8'hCD, b3: 8'hAB, last: 1'b0};
        vecs[1] = '{i: 16'h0001, q: 16'h0002, b0: 8'h01, b1: 8'h00, b2: 8'h02, b3: 8'h00, last: 1'b0};
        vecs[2] = '{i: 16'h0003, q: 16'h0004, b0: 8'h03, b1: 8'h00, b2: 8'h04, b3: 8'h00, last: 1'b0};
        vecs[3] = '{i: 16'h0005, q: 16'h0006, b0: 8'h05, b1: 8'h00, b2: 8'h06, b3: 8'h00, last: 1'b1};

        // ---- Reset values ----
        step();
        step();
        chk("reset valid", 32'(m_axis_valid), 32'd0);
        chk("reset data", 32'(m_axis_data), 32'd0);
        chk("reset last", 32'(m_axis_last), 32'd0);
        chk("reset overflow", 32'(overflow), 32'd0);
        chk("reset drop_count", 32'(drop_count), 32'd0);
        rst = 1'b0;
        mon_en = 1'b1;

        // ---- Basic stream, ready=1, with first-byte latency ----
        rdy_mode = 0;
        enable = 1'b1;
        step();
        s_valid = 1'b1;
        s_i = vecs[0].i;
        s_q = vecs[0].q;
        chk("latency cycle0 valid", 32'(m_axis_valid), 32'd0);
        step();
        s_valid = 1'b0;
        chk("latency cycle1 valid", 32'(m_axis_valid), 32'd0);
        step();
        chk("latency cycle2 valid", 32'(m_axis_valid), 32'd1);
        chk("latency cycle2 data", 32'(m_axis_data), 32'h34);
        step();
        for (int k = 1; k < 4; k++) send_sample(vecs[k].i, vecs[k].q, 3);
        exp_add_vecs();
        wait_bytes("basic", 16, 100);
        cmp_stream("basic");

        // ---- Same stream under toggling backpressure ----
        rdy_mode = 1;
        for (int k = 0; k < 4; k++) send_sample(vecs[k].i, vecs[k].q, 3);
        exp_add_vecs();
        wait_bytes("backpressure", 16, 200);
        cmp_stream("backpressure");
        enable = 1'b0;
        rdy_mode = 0;
        repeat (4) step();

        // ---- Overflow: 7 back-to-back samples into a stalled output ----
        do_reset();
        rdy_mode = 2;
        enable = 1'b1;
        step();
        for (int k = 0; k < 7; k++) begin
            s_valid = 1'b1;
            s_i = 16'h0100 + 16'(k);
            s_q = 16'h0200 + 16'(k);
            step();
        end
        s_valid = 1'b0;
        chk("ovf overflow", 32'(overflow), 32'd1);
        chk("ovf drop_count", 32'(drop_count), 32'd2);
        for (int k = 0; k < 5; k++) exp_add(16'h0100 + 16'(k), 16'h0200 + 16'(k), k == 3);
        rdy_mode = 0;
        repeat (40) step();
        chk("ovf emitted bytes", 32'(mon_q.size()), 32'd20);
        // One sample into the next frame: disabling pads three zero samples.
        enable = 1'b0;
        for (int k = 0; k < 3; k++) exp_add(16'd0, 16'd0, k == 2);
        wait_bytes("ovf pad", 32, 100);
        cmp_stream("ovf");

        // ---- Partial-frame padding then fresh frame ----
        do_reset();
        rdy_mode = 0;
        enable = 1'b1;
        step();
        send_sample(16'h1111, 16'h2222, 3);
        send_sample(16'h3333, 16'h4444, 3);
        enable = 1'b0;
        exp_add(16'h1111, 16'h2222, 1'b0);
        exp_add(16'h3333, 16'h4444, 1'b0);
        exp_add(16'd0, 16'd0, 1'b0);
        exp_add(16'd0, 16'd0, 1'b1);
        wait_bytes("pad", 16, 100);
        cmp_stream("pad");
        enable = 1'b1;
        step();
        for (int k = 0; k < 4; k++) send_sample(vecs[k].i, vecs[k].q, 3);
        exp_add_vecs();
        wait_bytes("after pad", 16, 100);
        cmp_stream("after pad");
        enable = 1'b0;
        repeat (4) step();

        // ---- Status: saturation, clear vs drop, plain clear ----
        do_reset();
        rdy_mode = 2;
        enable = 1'b1;
        step();
        s_valid = 1'b1;
        s_i = 16'h7777;
        s_q = 16'h8888;
        repeat (65545) step();
        chk("sat drop_count", 32'(drop_count), 32'hFFFF);
        chk("sat overflow", 32'(overflow), 32'd1);
        clear_status = 1'b1;
        step();
        clear_status = 1'b0;
        s_valid = 1'b0;
        chk("clear+drop overflow", 32'(overflow), 32'd1);
        chk("clear+drop drop_count", 32'(drop_count), 32'd1);
        clear_status = 1'b1;
        step();
        clear_status = 1'b0;
        chk("clear overflow", 32'(overflow), 32'd0);
        chk("clear drop_count", 32'(drop_count), 32'd0);

        // ---- Reset mid-frame ----
        do_reset();
        rdy_mode = 3;
        m_axis_ready = 1'b0;
        enable = 1'b1;
        step();
        for (int k = 0; k < 4; k++) begin
            s_valid = 1'b1;
            s_i = 16'h5A01 + 16'(k);
            s_q = 16'hC3D2 + 16'(k);
            step();
        end
        s_valid = 1'b0;
        m_axis_ready = 1'b1;
        step();
        step();
        m_axis_ready = 1'b0;
        chk("midrst valid before", 32'(m_axis_valid), 32'd1);
        chk("midrst byte2 data", 32'(m_axis_data), 32'hD2);
        mon_en = 1'b0;
        rst = 1'b1;
        enable = 1'b0;
        step();
        chk("midrst valid", 32'(m_axis_valid), 32'd0);
        chk("midrst last", 32'(m_axis_last), 32'd0);
        rst = 1'b0;
        mon_q.delete();
        mon_en = 1'b1;
        rdy_mode = 0;
        repeat (20) step();
        chk("midrst no stale bytes", 32'(mon_q.size()), 32'd0);
        chk("midrst idle valid", 32'(m_axis_valid), 32'd0);
        enable = 1'b1;
        step();
        for (int k = 0; k < 4; k++) send_sample(vecs[k].i, vecs[k].q, 0);
        exp_add_vecs();
        wait_bytes("restart", 16, 100);
        cmp_stream("restart");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
